ihex_dump_encoder: RTL and testbench

- Reads a contiguous range of program/data memory byte by byte.
- Serialises the range as Intel HEX text (data records type 00, then a single EOF record) onto an ASCII byte stream. The stream feeds the UART TX path, or a host readback FIFO.
- It is the writer counterpart of the HEX loader that fills ROM from a BINHEX download. Its output must round-trip through that loader bit-exactly.

---
 rtl/ihex_dump_encoder_if.sv | 28 ++
 rtl/ihex_dump_encoder.sv | 269 ++++++++++++++++++++++++++
 tb/tb_ihex_dump_encoder.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ihex_dump_encoder_if.sv
// Control, memory-read and character-stream signals of the Intel HEX dump
// encoder, bundled so the encoder and its environment share one bus handle.
interface ihex_dump_encoder_if #(
  parameter int ADDR_W = 15
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   length;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              done;

  // Environment side: issues dump requests, serves memory, sinks characters.
  modport master (
    output start, start_addr, length, mem_data, tx_ready,
    input  mem_addr, tx_data, tx_valid, busy, done
  );

  // Encoder side.
  modport slave (
    input  start, start_addr, length, mem_data, tx_ready,
    output mem_addr, tx_data, tx_valid, busy, done
  );
endinterface

// File: rtl/ihex_dump_encoder.sv
// Intel HEX dump encoder: reads a contiguous byte range from a synchronous
// memory and emits it as type-00 data records followed by one EOF record,
// one ASCII character per stream handshake. Addresses wrap modulo 2^ADDR_W
// and a record never straddles that wrap. ADDR_W must not exceed 16 so the
// address field fits AAAA; REC_LEN must lie in 1..255.
module ihex_dump_encoder #(
  parameter int ADDR_W  = 15,
  parameter int REC_LEN = 16
) (
  input logic                clk,
  input logic                rst_n,
  ihex_dump_encoder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_FETCH,
    S_WAIT,
    S_DATA,
    S_CKS,
    S_EOL,
    S_EOF
  } state_t;

  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_ONE   = 8'h31;
  localparam logic [7:0] CH_F     = 8'h46;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  // Uppercase ASCII hex digit for one nibble.
  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    logic [7:0] c;
    if (nib < 4'd10) c = CH_ZERO + {4'h0, nib};
    else             c = 8'h37 + {4'h0, nib};   // 0x37 + 10 = 'A'
    return c;
  endfunction

  // Bytes in the next record: limited by REC_LEN, the bytes still to dump,
  // and the distance to the top of the address space.
  function automatic logic [7:0] rec_len(input logic [ADDR_W-1:0] a,
                                         input logic [ADDR_W:0]   rem);
    logic [ADDR_W:0] to_wrap;
    logic [ADDR_W:0] n;
    to_wrap = {1'b1, {ADDR_W{1'b0}}} - {1'b0, a};
    n       = (ADDR_W+1)'(REC_LEN);
    if (rem < n)     n = rem;
    if (to_wrap < n) n = to_wrap;
    return n[7:0];
  endfunction

  // Header characters ':' LL AAAA "00" by position 0..8.
  function automatic logic [7:0] hdr_char(input logic [3:0]  i,
                                          input logic [7:0]  ll,
                                          input logic [15:0] a);
    logic [7:0] c;
    case (i)
      4'd0:    c = CH_COLON;
      4'd1:    c = hex_char(ll[7:4]);
      4'd2:    c = hex_char(ll[3:0]);
      4'd3:    c = hex_char(a[15:12]);
      4'd4:    c = hex_char(a[11:8]);
      4'd5:    c = hex_char(a[7:4]);
      4'd6:    c = hex_char(a[3:0]);
      default: c = CH_ZERO;                     // record type "00"
    endcase
    return c;
  endfunction

  // EOF record ":00000001FF" CR LF by position 0..12.
  function automatic logic [7:0] eof_char(input logic [3:0] i);
    logic [7:0] c;
    case (i)
      4'd0:    c = CH_COLON;
      4'd8:    c = CH_ONE;
      4'd9:    c = CH_F;
      4'd10:   c = CH_F;
      4'd11:   c = CH_CR;
      4'd12:   c = CH_LF;
      default: c = CH_ZERO;
    endcase
    return c;
  endfunction

  state_t            state_q;
  logic [3:0]        idx_q;       // character position inside the current state
  logic [ADDR_W-1:0] addr_q;      // address of the next byte to dump
  logic [ADDR_W:0]   rem_q;       // bytes still to dump
  logic [7:0]        ll_q;        // length of the record being emitted
  logic [7:0]        cnt_q;       // bytes left in the current record
  logic [7:0]        cks_q;       // running byte sum of the current record
  logic [7:0]        byte_q;      // data byte being printed
  logic [7:0]        tx_data_q;
  logic              tx_valid_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic [15:0] a16_d;
  logic [15:0] sa16_d;
  logic [7:0]  ll_start_d;
  logic [7:0]  ll_next_d;
  logic [7:0]  sum_d;
  logic [7:0]  cks_last_d;
  logic [7:0]  cks_neg_d;
  logic        hs_d;

  // Record lengths, checksum candidates and the handshake strobe.
  always_comb begin
    a16_d      = 16'(addr_q);
    sa16_d     = 16'(bus.start_addr);
    ll_start_d = rec_len(bus.start_addr, bus.length);
    ll_next_d  = rec_len(addr_q, rem_q);
    sum_d      = cks_q + byte_q;
    cks_last_d = 8'd0 - sum_d;
    cks_neg_d  = 8'd0 - cks_q;
    hs_d       = tx_valid_q & bus.tx_ready;
  end

  // Dump sequencer. The character register is reloaded on the same edge as
  // its handshake, so consecutive non-data characters go out back to back;
  // tx_valid only drops during the FETCH/WAIT memory round trip.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      addr_q     <= '0;
      rem_q      <= '0;
      ll_q       <= '0;
      cnt_q      <= '0;
      cks_q      <= '0;
      byte_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            addr_q     <= bus.start_addr;
            rem_q      <= bus.length;
            busy_q     <= 1'b1;
            tx_valid_q <= 1'b1;
            tx_data_q  <= CH_COLON;
            idx_q      <= '0;
            if (bus.length == '0) begin
              state_q <= S_EOF;
            end else begin
              state_q <= S_HDR;
              ll_q    <= ll_start_d;
              cnt_q   <= ll_start_d;
              cks_q   <= ll_start_d + sa16_d[15:8] + sa16_d[7:0];
            end
          end
        end

        S_HDR: begin
          if (hs_d) begin
            if (idx_q == 4'd8) begin
              state_q    <= S_FETCH;
              tx_valid_q <= 1'b0;
              mem_addr_q <= addr_q;
            end else begin
              idx_q     <= idx_q + 4'd1;
              tx_data_q <= hdr_char(idx_q + 4'd1, ll_q, a16_d);
            end
          end
        end

        // Address was registered on entry; memory samples it this cycle.
        S_FETCH: state_q <= S_WAIT;

        // Read data is valid now; capture it and present its high digit.
        S_WAIT: begin
          byte_q     <= bus.mem_data;
          tx_data_q  <= hex_char(bus.mem_data[7:4]);
          tx_valid_q <= 1'b1;
          idx_q      <= '0;
          state_q    <= S_DATA;
        end

        S_DATA: begin
          if (hs_d) begin
            if (idx_q == 4'd0) begin
              idx_q     <= 4'd1;
              tx_data_q <= hex_char(byte_q[3:0]);
            end else begin
              cks_q  <= sum_d;
              addr_q <= addr_q + ADDR_W'(1);
              rem_q  <= rem_q - (ADDR_W+1)'(1);
              cnt_q  <= cnt_q - 8'd1;
              if (cnt_q == 8'd1) begin
                state_q   <= S_CKS;
                idx_q     <= '0;
                tx_data_q <= hex_char(cks_last_d[7:4]);
              end else begin
                state_q    <= S_FETCH;
                tx_valid_q <= 1'b0;
                mem_addr_q <= addr_q + ADDR_W'(1);
              end
            end
          end
        end

        // cks_q holds the full record sum here; print its two's complement.
        S_CKS: begin
          if (hs_d) begin
            if (idx_q == 4'd0) begin
              idx_q     <= 4'd1;
              tx_data_q <= hex_char(cks_neg_d[3:0]);
            end else begin
              state_q   <= S_EOL;
              idx_q     <= '0;
              tx_data_q <= CH_CR;
            end
          end
        end

        S_EOL: begin
          if (hs_d) begin
            if (idx_q == 4'd0) begin
              idx_q     <= 4'd1;
              tx_data_q <= CH_LF;
            end else begin
              idx_q     <= '0;
              tx_data_q <= CH_COLON;
              if (rem_q != '0) begin
                state_q <= S_HDR;
                ll_q    <= ll_next_d;
                cnt_q   <= ll_next_d;
                cks_q   <= ll_next_d + a16_d[15:8] + a16_d[7:0];
              end else begin
                state_q <= S_EOF;
              end
            end
          end
        end

        S_EOF: begin
          if (hs_d) begin
            if (idx_q == 4'd12) begin
              state_q    <= S_IDLE;
              tx_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              idx_q     <= idx_q + 4'd1;
              tx_data_q <= eof_char(idx_q + 4'd1);
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_addr = mem_addr_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_ihex_dump_encoder.sv
// Bench for ihex_dump_encoder: a text-level Intel HEX model predicts every
// character, data-byte address and the done pulse; a monitor compares the DUT
// against it each cycle, and a small HEX loader parses the received text back
// into bytes that must match memory.
`timescale 1ns/1ps
module tb_ihex_dump_encoder;
  localparam int ADDR_W   = 15;
  localparam int REC_LEN  = 16;
  localparam int MEM_SIZE = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ihex_dump_encoder_if #(.ADDR_W(ADDR_W)) bus ();
  ihex_dump_encoder #(.ADDR_W(ADDR_W), .REC_LEN(REC_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] mem [MEM_SIZE];
  always @(posedge clk) bus.mem_data <= mem[bus.mem_addr];

  int total = 0;
  int bad = 0;
  byte unsigned exp_q[$];
  bit           exp_hi_q[$];
  int           exp_addr_q[$];
  byte unsigned rx_q[$];
  int  ready_mode = 0;
  bit  stall_req = 0;
  int  done_cnt = 0;
  int  cyc = 0;
  int  last_acc = 0;
  bit  first_acc = 1;
  bit  prev_pend = 0;
  bit  prev_valid = 0;
  logic [7:0] prev_data = '0;
  string HEXS = "0123456789ABCDEF";

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_str(input string name, input string act, input string req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, req);
    end
  endtask

  // Printable form of a character queue: CR as '~', LF as '|'.
  function automatic string q2s(input byte unsigned q[$]);
    string s = "";
    foreach (q[i]) begin
      if (q[i] == 8'h0D)      s = {s, "~"};
      else if (q[i] == 8'h0A) s = {s, "|"};
      else                    s = $sformatf("%s%c", s, q[i]);
    end
    return s;
  endfunction

  function automatic int hexval(input byte unsigned c);
    return (c >= 8'h41) ? int'(c) - 55 : int'(c) - 48;
  endfunction

  task automatic push_ch(input byte unsigned c, input bit hi);
    exp_q.push_back(c);
    exp_hi_q.push_back(hi);
  endtask

  task automatic push_hex(input int v, input bit data);
    push_ch(HEXS[(v >> 4) & 15], data);
    push_ch(HEXS[v & 15], 1'b0);
  endtask

  // Reference: the whole text stream for a dump, from the Intel HEX rules.
  task automatic model_dump(input int sa, input int len);
    int a, rem, n, sum, b;
    string eofs;
    exp_q.delete(); exp_hi_q.delete(); exp_addr_q.delete();
    a = sa; rem = len;
    while (rem > 0) begin
      n = rem;
      if (n > REC_LEN) n = REC_LEN;
      if (n > MEM_SIZE - a) n = MEM_SIZE - a;
      push_ch(8'h3A, 1'b0);
      push_hex(n, 1'b0); push_hex(a >> 8, 1'b0); push_hex(a & 255, 1'b0); push_hex(0, 1'b0);
      sum = n + (a >> 8) + (a & 255);
      for (int i = 0; i < n; i++) begin
        b = int'(mem[(a + i) % MEM_SIZE]);
        push_hex(b, 1'b1);
        sum += b;
        exp_addr_q.push_back((a + i) % MEM_SIZE);
      end
      push_hex((256 - (sum % 256)) % 256, 1'b0);
      push_ch(8'h0D, 1'b0); push_ch(8'h0A, 1'b0);
      a = (a + n) % MEM_SIZE;
      rem -= n;
    end
    eofs = ":00000001FF";
    for (int i = 0; i < eofs.len(); i++) push_ch(eofs[i], 1'b0);
    push_ch(8'h0D, 1'b0); push_ch(8'h0A, 1'b0);
  endtask

  // Stream sink: full-rate, ~30% random, with an optional 5-cycle stall
  // placed on a data high digit.
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 0) begin
        bus.tx_ready = 1'b1;
      end else if (stall_req && bus.tx_valid && exp_hi_q.size() > 0 && exp_hi_q[0]) begin
        bus.tx_ready = 1'b0;
        stall_req = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
      end else begin
        bus.tx_ready = ($urandom_range(0, 99) < 30);
      end
    end
  end

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    byte unsigned c;
    bit hi;
    if (!rst_n) begin
      prev_pend = 1'b0;
      prev_valid = 1'b0;
    end else begin
      cyc++;
      if (prev_pend) begin
        check("hold_valid", int'(bus.tx_valid), 1);
        check("hold_data", int'(bus.tx_data), int'(prev_data));
      end
      if (bus.tx_valid && !prev_valid && bus.tx_data != 8'h3A) begin
        if (exp_addr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL mem_addr: unexpected read of %04h", bus.mem_addr);
        end else begin
          check("mem_addr", int'(bus.mem_addr), exp_addr_q.pop_front());
        end
      end
      if (bus.tx_valid && bus.tx_ready) begin
        rx_q.push_back(bus.tx_data);
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_char: got %02h expected none", bus.tx_data);
        end else begin
          c  = exp_q.pop_front();
          hi = exp_hi_q.pop_front();
          check("char", int'(bus.tx_data), int'(c));
          if (ready_mode == 0 && !first_acc) begin
            if (hi) check("gap_data_le3", int'((cyc - last_acc) <= 3), 1);
            else    check("gap_ctrl", cyc - last_acc, 1);
          end
          first_acc = 1'b0;
          last_acc = cyc;
        end
      end
      if (bus.done) begin
        done_cnt++;
        check("busy_low_with_done", int'(bus.busy), 0);
      end
      prev_pend  = bus.tx_valid && !bus.tx_ready;
      prev_valid = bus.tx_valid;
      prev_data  = bus.tx_data;
    end
  end

  // HEX loader: parse received text, verify checksums and bytes vs memory.
  task automatic roundtrip(input int sa, input int len);
    int p = 0, exp_a = sa, loaded = 0, errs = 0, eof = 0, sum, ra;
    byte unsigned rec[$];
    while (p < rx_q.size() && eof == 0) begin
      if (rx_q[p] != 8'h3A) begin errs++; break; end
      p++;
      rec.delete();
      while (p + 1 < rx_q.size() && rx_q[p] != 8'h0D) begin
        rec.push_back(8'(hexval(rx_q[p]) * 16 + hexval(rx_q[p+1])));
        p += 2;
      end
      p += 2;
      if (rec.size() < 5) begin errs++; break; end
      sum = 0;
      foreach (rec[i]) sum += int'(rec[i]);
      if (sum % 256 != 0) errs++;
      if (int'(rec[0]) + 5 != rec.size()) begin errs++; break; end
      ra = (int'(rec[1]) << 8) | int'(rec[2]);
      if (rec[3] == 8'h01) eof = 1;
      else begin
        for (int i = 0; i < int'(rec[0]); i++) begin
          if (ra + i != exp_a) errs++;
          if (rec[4+i] != mem[exp_a]) errs++;
          exp_a = (exp_a + 1) % MEM_SIZE;
          loaded++;
        end
      end
    end
    check("roundtrip_errs", errs, 0);
    check("roundtrip_bytes", loaded, len);
    check("roundtrip_eof", eof, 1);
  endtask

  task automatic run_dump(input int sa, input int len, input int mode, input bit abuse);
    int budget, n, exp_len;
    model_dump(sa, len);
    exp_len = exp_q.size();
    rx_q.delete();
    done_cnt = 0;
    ready_mode = mode;
    first_acc = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.start_addr = ADDR_W'(sa);
    bus.length = (ADDR_W+1)'(len);
    @(negedge clk);
    bus.start = 1'b0;
    bus.start_addr = ADDR_W'($urandom);
    bus.length = (ADDR_W+1)'($urandom);
    check("busy_after_start", int'(bus.busy), 1);
    budget = 400 + 60 * len;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
      if (abuse && n == 10) begin
        bus.start = 1'b1; bus.start_addr = ADDR_W'(123); bus.length = (ADDR_W+1)'(5);
      end
      if (abuse && n == 11) bus.start = 1'b0;
    end
    repeat (20) @(negedge clk);
    check("done_count", done_cnt, 1);
    check("chars_left", exp_q.size(), 0);
    check("chars_received", rx_q.size(), exp_len);
    check("idle_busy", int'(bus.busy), 0);
    check("idle_valid", int'(bus.tx_valid), 0);
    roundtrip(sa, len);
    $display("dump sa=%04h len=%0d mode=%0d chars=%0d done=%0d cycles=%0d", sa, len, mode, rx_q.size(), done_cnt, n);
    if (done_cnt == 0) begin
      rst_n = 1'b0; repeat (2) @(negedge clk); rst_n = 1'b1;
    end
  endtask

  initial begin
    string base;
    int wrap_addrs[$];
    bus.start = 1'b0;
    bus.start_addr = '0;
    bus.length = '0;
    foreach (mem[i]) mem[i] = 8'($urandom);
    mem[0] = 8'h0C; mem[1] = 8'h94; mem[2] = 8'h5D; mem[3] = 8'h00;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_valid", int'(bus.tx_valid), 0);
    check("rst_tx_data", int'(bus.tx_data), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_mem_addr", int'(bus.mem_addr), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Empty dump: only the EOF record, memory address untouched.
    model_dump(0, 0);
    check_str("model_empty", q2s(exp_q), ":00000001FF~|");
    run_dump(0, 0, 0, 1'b0);
    check_str("empty_stream", q2s(rx_q), ":00000001FF~|");
    check("empty_mem_addr", int'(bus.mem_addr), 0);

    // Basic four-byte record.
    model_dump(0, 4);
    check_str("model_basic", q2s(exp_q), ":040000000C945D00FF~|:00000001FF~|");
    run_dump(0, 4, 0, 1'b0);
    base = q2s(rx_q);
    check_str("basic_stream", base, ":040000000C945D00FF~|:00000001FF~|");
    check("basic_len", rx_q.size(), 34);

    // Record splitting at REC_LEN.
    model_dump(0, 20);
    check("model_split_len", exp_q.size(), 79);
    check_str("model_split_r1", q2s(exp_q).substr(0, 8), ":10000000");
    check_str("model_split_r2", q2s(exp_q).substr(45, 53), ":04001000");
    run_dump(0, 20, 0, 1'b0);

    // Address-space wrap splits the record.
    model_dump(32'h7FFE, 4);
    check_str("model_wrap_r1", q2s(exp_q).substr(0, 8), ":027FFE00");
    check_str("model_wrap_r2", q2s(exp_q).substr(17, 25), ":02000000");
    wrap_addrs = exp_addr_q;
    check("model_wrap_a0", wrap_addrs[0], 32'h7FFE);
    check("model_wrap_a2", wrap_addrs[2], 0);
    run_dump(32'h7FFE, 4, 0, 1'b0);

    // Backpressure with a stall on a data digit.
    stall_req = 1'b1;
    run_dump(0, 4, 1, 1'b0);
    check_str("bp_same_stream", q2s(rx_q), base);
    stall_req = 1'b1;
    run_dump(0, 20, 1, 1'b0);

    // Randomized ranges, some near the wrap.
    for (int t = 0; t < 6; t++) begin
      int sa, len;
      sa  = (t % 2 == 0) ? $urandom_range(0, MEM_SIZE - 1) : MEM_SIZE - $urandom_range(1, 20);
      len = $urandom_range(1, 70);
      stall_req = (t == 2);
      run_dump(sa, len, (t == 5) ? 0 : 1, 1'b0);
    end

    // start while busy must be ignored.
    run_dump(32'h200, 30, 0, 1'b1);

    // Reset in the middle of a record.
    model_dump(32'h100, 40);
    ready_mode = 1;
    @(negedge clk);
    bus.start = 1'b1; bus.start_addr = ADDR_W'(32'h100); bus.length = (ADDR_W+1)'(40);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (60) @(negedge clk);
    check("abort_busy_before", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort_tx_valid", int'(bus.tx_valid), 0);
    check("abort_busy", int'(bus.busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_idle_valid", int'(bus.tx_valid), 0);
    run_dump(32'h20, 10, 1, 1'b0);
    check("abort_first_colon", (rx_q.size() > 0) ? int'(rx_q[0]) : -1, 32'h3A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
